harris_nms: RTL
===============

// Module: harris_nms
// PURPOSE
//  Downstream stage of the Harris corner pipeline. Raster-scans the Harris score memory
//  through a single read port. Applies 3x3 non-maximum suppression plus a threshold.
//  Writes the packed (row,col) of every surviving corner to a corner-list memory through
//  a write port.
//  Started by a one-cycle t pulse. Reports done, corner count and overflow.
// PARAMETERS
//  IMG_W        32    image width in pixels (>=3)
//  IMG_H        32    image height in pixels (>=3)
//  DATA_W       32    score width; scores are signed two's complement
//  MAX_CORNERS  256   corner-list memory depth
//  localparams: N=IMG_W*IMG_H, ADDR_W=$clog2(N), CADDR_W=$clog2(MAX_CORNERS)
// PORTS
//  clk                  in   1        clock
//  rst                  in   1        asynchronous reset, active-low
//  t                    in   1        start pulse
//  threshold            in   DATA_W   signed threshold, sampled on accepted t
//  harris_p0_addr_data  out  ADDR_W   score read address
//  harris_p0_addr_en    out  1        address valid (== rd_en)
//  harris_p0_rd_en      out  1        read enable; data valid 1 cycle later
//  harris_p0_rd_data    in   DATA_W   score read data
//  corners_p0_addr_data out  CADDR_W  corner-list write address
//  corners_p0_addr_en   out  1        address valid (== wr_en)
//  corners_p0_wr_en     out  1        write enable
//  corners_p0_wr_data   out  32       {16'(row),16'(col)}
//  busy                 out  1        scan in progress
//  done                 out  1        one-cycle completion pulse
//  num_corners          out  CADDR_W+1 corners found, saturating at MAX_CORNERS
//  overflow             out  1        more than MAX_CORNERS corners detected
// BEHAVIOUR
//  - Reset (rst=0, any time incl. mid-scan):
//    - state IDLE; all outputs 0; counters and window cleared.
//    - Memories are left untouched.
//  - FSM IDLE->SCAN->DRAIN->DONE->IDLE.
//    - t in IDLE is accepted; t in any other state is ignored.
//    - On acceptance: threshold is latched, num_corners and overflow are cleared.
//  - Timing, with accepted t at cycle 0:
//    - Reads are issued at cycles 1..N, addresses 0..N-1, one per cycle, no gaps.
//    - Data arrives at cycles 2..N+1.
//    - busy=1 from cycle 1 through cycle N+2.
//    - done=1 at cycle N+3 only.
//    - num_corners and overflow hold their values until the next accepted t.
//  - Window:
//    - Two line buffers of IMG_W entries plus a 3x3 register window.
//    - Arrival of pixel (r,c) completes the window for centre (r-1,c-1).
//    - That centre is evaluated only if 1<=r-1<=IMG_H-2 and 1<=c-1<=IMG_W-2.
//    - Border pixels are never corners, and the window never mixes rows across the
//      column wrap.
//  - Corner rule (signed compare):
//    - centre > threshold, AND
//    - centre > each of the 4 neighbours preceding it in raster order, AND
//    - centre >= each of the 4 neighbours following it.
//    - Equal plateaus therefore yield exactly one corner: the first in raster order.
//  - Write:
//    - A corner decided on data-arrival cycle k is written at cycle k+1.
//    - Address = num_corners before increment.
//    - At most one write per cycle; writes are in raster order.
//  - Overflow:
//    - Once num_corners==MAX_CORNERS, further corners are not written.
//    - overflow is set to 1 and stays set; num_corners stays at MAX_CORNERS.
//  - Row and column come from internal counters, not from address division.
//    - Counters wrap col IMG_W-1 -> 0 with row+1.
// STRUCTURE
//  - harris_pkg holds:
//    - score_t (signed DATA_W)
//    - IMG_W / IMG_H defaults shared with the harris stage
//    - function pack_coord(row,col) -> 32-bit word
//  - Sub-module harris_nms_linebuf: two-row shift buffer, depth IMG_W, one push per cycle.
//    - Outputs column taps for rows r-2 and r-1.
//  - Top holds the FSM, address/coordinate counters, 3x3 window, compare tree, writer.
// TESTING
//  - All-zero image, threshold=0:
//    - no writes, num_corners=0, overflow=0.
//    - done exactly 1027 cycles after t (N=1024).
//  - Single score 100 at (5,7), rest 0, threshold=10:
//    - one write, addr 0, data 0x0005_0007; num_corners=1.
//  - Score 100 at border (0,9) plus 100 at (31,31) -> no writes.
//  - Plateau: 50 at (10,10) and (10,11), rest 0, threshold=10:
//    - exactly one write, data 0x000A_000A.
//  - Bench with MAX_CORNERS=4, isolated 100-peaks at every (2i+1,2j+1):
//    - 4 writes at addrs 0..3, in raster order.
//    - num_corners=4, overflow=1.
//  - Signed scores and control robustness:
//    - Background -100, isolated -1 at (3,3), threshold=-5 -> one corner 0x0003_0003.
//    - Extra t pulses at cycles 10 and 500 are ignored.
//    - rst=0 at cycle 600 clears all outputs; a fresh t afterwards completes correctly.

Source files
------------

// File: rtl/harris_pkg.sv
// Shared types and helpers for the Harris corner pipeline.
// Score type, default image geometry and corner coordinate packing.
package harris_pkg;
  localparam int HARRIS_IMG_W  = 32;
  localparam int HARRIS_IMG_H  = 32;
  localparam int HARRIS_DATA_W = 32;

  typedef logic signed [HARRIS_DATA_W-1:0] score_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } nms_state_e;

  function automatic logic [31:0] pack_coord(
    input logic [15:0] row,
    input logic [15:0] col
  );
    return {row, col};
  endfunction
endpackage

// File: rtl/harris_nms_if.sv
// Memory-side bundle of the NMS stage: score read port and
// corner-list write port.
interface harris_nms_if #(
  parameter int ADDR_W  = 10,
  parameter int CADDR_W = 8,
  parameter int DATA_W  = 32
);
  logic [ADDR_W-1:0]  harris_p0_addr_data;
  logic               harris_p0_addr_en;
  logic               harris_p0_rd_en;
  logic [DATA_W-1:0]  harris_p0_rd_data;
  logic [CADDR_W-1:0] corners_p0_addr_data;
  logic               corners_p0_addr_en;
  logic               corners_p0_wr_en;
  logic [31:0]        corners_p0_wr_data;

  modport master (
    output harris_p0_addr_data,
    output harris_p0_addr_en,
    output harris_p0_rd_en,
    input  harris_p0_rd_data,
    output corners_p0_addr_data,
    output corners_p0_addr_en,
    output corners_p0_wr_en,
    output corners_p0_wr_data
  );

  modport slave (
    input  harris_p0_addr_data,
    input  harris_p0_addr_en,
    input  harris_p0_rd_en,
    output harris_p0_rd_data,
    input  corners_p0_addr_data,
    input  corners_p0_addr_en,
    input  corners_p0_wr_en,
    input  corners_p0_wr_data
  );
endinterface

// File: rtl/harris_nms_linebuf.sv
// Two-row shift buffer: taps give the same column one and two
// rows above the pixel being pushed.
module harris_nms_linebuf #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2
);
  logic [DATA_W-1:0] r1 [DEPTH];
  logic [DATA_W-1:0] r2 [DEPTH];

  assign tap1 = r1[DEPTH-1];
  assign tap2 = r2[DEPTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r1[i] <= '0;
        r2[i] <= '0;
      end
    end else if (push) begin
      r1[0] <= din;
      r2[0] <= r1[DEPTH-1];
      for (int i = 1; i < DEPTH; i++) begin
        r1[i] <= r1[i-1];
        r2[i] <= r2[i-1];
      end
    end
  end
endmodule

// File: rtl/harris_nms.sv
// Harris 3x3 non-maximum suppression: raster-scans the score memory,
// thresholds, and writes surviving corner coordinates to a list.
module harris_nms
  import harris_pkg::*;
#(
  parameter int IMG_W       = HARRIS_IMG_W,
  parameter int IMG_H       = HARRIS_IMG_H,
  parameter int DATA_W      = HARRIS_DATA_W,
  parameter int MAX_CORNERS = 256,
  localparam int N          = IMG_W * IMG_H,
  localparam int ADDR_W     = $clog2(N),
  localparam int CADDR_W    = $clog2(MAX_CORNERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     t,
  input  logic signed [DATA_W-1:0] threshold,
  harris_nms_if.master             mem,
  output logic                     busy,
  output logic                     done,
  output logic [CADDR_W:0]         num_corners,
  output logic                     overflow
);
  typedef logic signed [DATA_W-1:0] pix_t;

  localparam int NCW = CADDR_W + 1;
  localparam logic [NCW-1:0]    MAXC      = NCW'(MAX_CORNERS);
  localparam logic [15:0]       LAST_COL  = 16'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  nms_state_e state, state_nx;

  logic [ADDR_W-1:0]  rd_addr;
  logic               drain_cnt;
  logic               dvld;
  pix_t               thr_q;
  logic [15:0]        row, col;
  logic [DATA_W-1:0]  tap1_u, tap2_u;
  pix_t               din, tap1, tap2;
  pix_t               w1 [3];
  pix_t               w2 [3];
  logic               accept, in_core, is_corner;
  logic               wr_q;
  logic [CADDR_W-1:0] waddr_q;
  logic [31:0]        wdata_q;

  assign accept = (state == S_IDLE) && t;
  assign din    = $signed(mem.harris_p0_rd_data);
  assign tap1   = $signed(tap1_u);
  assign tap2   = $signed(tap2_u);

  assign busy = (state == S_SCAN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign mem.harris_p0_rd_en        = (state == S_SCAN);
  assign mem.harris_p0_addr_en      = (state == S_SCAN);
  assign mem.harris_p0_addr_data    = rd_addr;
  assign mem.corners_p0_wr_en       = wr_q;
  assign mem.corners_p0_addr_en     = wr_q;
  assign mem.corners_p0_addr_data   = waddr_q;
  assign mem.corners_p0_wr_data     = wdata_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (t) state_nx = S_SCAN;
      S_SCAN:  if (rd_addr == LAST_ADDR) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
      dvld      <= 1'b0;
      thr_q     <= '0;
    end else begin
      state     <= state_nx;
      dvld      <= (state == S_SCAN);
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      if (accept) begin
        thr_q   <= threshold;
        rd_addr <= '0;
      end else if (state == S_SCAN) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // row/col track the pixel arriving this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      row <= '0;
      col <= '0;
    end else if (dvld) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  harris_nms_linebuf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_linebuf (
    .clk  (clk),
    .rst  (rst),
    .push (dvld),
    .din  (mem.harris_p0_rd_data),
    .tap1 (tap1_u),
    .tap2 (tap2_u)
  );

  // w1 = centre column, w2 = left column; index 0 top, 2 bottom
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        w1[i] <= '0;
        w2[i] <= '0;
      end
    end else if (dvld) begin
      for (int i = 0; i < 3; i++) w2[i] <= w1[i];
      w1[0] <= tap2;
      w1[1] <= tap1;
      w1[2] <= din;
    end
  end

  assign in_core = dvld && (row >= 16'd2) && (col >= 16'd2);

  always_comb begin
    is_corner = in_core
      && (w1[1] >  thr_q)
      && (w1[1] >  w2[0])
      && (w1[1] >  w1[0])
      && (w1[1] >  tap2)
      && (w1[1] >  w2[1])
      && (w1[1] >= tap1)
      && (w1[1] >= w2[2])
      && (w1[1] >= w1[2])
      && (w1[1] >= din);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      num_corners <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (accept) begin
        num_corners <= '0;
        overflow    <= 1'b0;
      end else if (is_corner) begin
        if (num_corners == MAXC) begin
          overflow <= 1'b1;
        end else begin
          wr_q        <= 1'b1;
          waddr_q     <= num_corners[CADDR_W-1:0];
          wdata_q     <= pack_coord(row - 16'd1, col - 16'd1);
          num_corners <= num_corners + 1'b1;
        end
      end
    end
  end
endmodule
